// File: rtl/servo_slew_limiter.sv
// Rate limiter for the left/right continuous-rotation servo commands: each channel
// moves toward its target by at most MAX_STEP codes per step tick, braking to NEUTRAL when disabled.
module servo_slew_limiter #(
    parameter int         CLK_FREQ = 100_000_000,
    parameter int         STEP_HZ  = 1000,
    parameter int         MAX_STEP = 4,
    parameter logic [7:0] NEUTRAL  = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] target_l,
    input  logic [7:0] target_r,
    output logic [7:0] servo_l,
    output logic [7:0] servo_r,
    output logic       settled,
    output logic [1:0] state
);

    localparam int              DIV     = CLK_FREQ / STEP_HZ;
    localparam int              CW      = $clog2(DIV);
    localparam logic [CW-1:0]   TICK_AT = CW'(DIV - 1);
    localparam logic [7:0]      STEP8   = 8'(MAX_STEP);
    localparam logic signed [8:0] STEP9 = 9'(MAX_STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_BRAKE = 2'd3
    } state_t;

    // Move cur toward tgt by at most MAX_STEP; lands exactly when within reach.
    function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt);
        logic signed [8:0] d;
        d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (d > STEP9) begin
            slew_step = cur + STEP8;
        end else if (d < -STEP9) begin
            slew_step = cur - STEP8;
        end else begin
            slew_step = tgt;
        end
    endfunction

    logic          en_q;
    logic [7:0]    tl_q;
    logic [7:0]    tr_q;
    logic [CW-1:0] cnt_r;
    logic [7:0]    servo_l_r;
    logic [7:0]    servo_r_r;
    logic          settled_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic          tick_s;
    logic [7:0]    eff_l_s;
    logic [7:0]    eff_r_s;
    logic          at_target_s;

    // Register the drive inputs once per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= 1'b0;
            tl_q <= NEUTRAL;
            tr_q <= NEUTRAL;
        end else begin
            en_q <= enable;
            tl_q <= target_l;
            tr_q <= target_r;
        end
    end

    // Step-period divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Effective targets, tick strobe and at-target compare
    always_comb begin
        tick_s      = (cnt_r == TICK_AT);
        eff_l_s     = en_q ? tl_q : NEUTRAL;
        eff_r_s     = en_q ? tr_q : NEUTRAL;
        at_target_s = (servo_l_r == eff_l_s) && (servo_r_r == eff_r_s);
    end

    // Slewed outputs move only on tick edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            servo_l_r <= NEUTRAL;
            servo_r_r <= NEUTRAL;
        end else if (tick_s) begin
            servo_l_r <= slew_step(servo_l_r, eff_l_s);
            servo_r_r <= slew_step(servo_r_r, eff_r_s);
        end else begin
            servo_l_r <= servo_l_r;
            servo_r_r <= servo_r_r;
        end
    end

    // Settled flag and FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settled_r <= 1'b1;
            state_r   <= ST_IDLE;
        end else begin
            settled_r <= at_target_s;
            state_r   <= state_nxt_s;
        end
    end

    // Next-state logic; state is reporting only and never gates the step rule
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en_q) begin
                    state_nxt_s = ST_RAMP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RAMP, ST_HOLD: begin
                if (!en_q) begin
                    state_nxt_s = ST_BRAKE;
                end else if (at_target_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RAMP;
                end
            end
            ST_BRAKE: begin
                if (en_q) begin
                    state_nxt_s = ST_RAMP;
                end else if (at_target_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BRAKE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign servo_l = servo_l_r;
    assign servo_r = servo_r_r;
    assign settled = settled_r;
    assign state   = state_r;

endmodule

// File: tb/tb_servo_slew_limiter.sv
// Self-checking bench for servo_slew_limiter: directed scenarios plus randomized
// stimulus compared cycle by cycle against an integer reference model.
module tb_servo_slew_limiter;

    localparam int DIV  = 10;
    localparam int MAXS = 4;
    localparam int NEU  = 128;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       enable   = 1'b0;
    logic [7:0] target_l = 8'd128;
    logic [7:0] target_r = 8'd128;
    logic [7:0] servo_l;
    logic [7:0] servo_r;
    logic       settled;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state (plain integers)
    int m_en, m_tl, m_tr, m_l, m_r, m_state, m_settled, m_cnt;
    bit m_ticked;

    servo_slew_limiter #(
        .CLK_FREQ(100),
        .STEP_HZ (10),
        .MAX_STEP(MAXS),
        .NEUTRAL (8'd128)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .target_l(target_l),
        .target_r(target_r),
        .servo_l (servo_l),
        .servo_r (servo_r),
        .settled (settled),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int step_to(input int cur, input int tgt);
        if (tgt - cur > MAXS)       return cur + MAXS;
        else if (tgt - cur < -MAXS) return cur - MAXS;
        else                        return tgt;
    endfunction

    task automatic model_reset();
        m_en = 0; m_tl = NEU; m_tr = NEU;
        m_l = NEU; m_r = NEU;
        m_state = 0; m_settled = 1; m_cnt = 0; m_ticked = 1'b0;
    endtask

    // advance the model by one rising clock edge
    task automatic model_edge();
        int el, er, ns;
        bit at, tick;
        if (rst) begin
            model_reset();
        end else begin
            el   = (m_en != 0) ? m_tl : NEU;
            er   = (m_en != 0) ? m_tr : NEU;
            tick = (m_cnt == DIV - 1);
            at   = (m_l == el) && (m_r == er);
            case (m_state)
                0:       ns = (m_en != 0) ? 1 : 0;
                1, 2:    ns = (m_en == 0) ? 3 : (at ? 2 : 1);
                3:       ns = (m_en != 0) ? 1 : (at ? 0 : 3);
                default: ns = 0;
            endcase
            if (tick) begin
                m_l = step_to(m_l, el);
                m_r = step_to(m_r, er);
            end
            m_settled = at ? 1 : 0;
            m_state   = ns;
            m_en      = enable ? 1 : 0;
            m_tl      = int'(target_l);
            m_tr      = int'(target_r);
            m_cnt     = (m_cnt + 1) % DIV;
            m_ticked  = tick;
        end
    endtask

    task automatic compare_all();
        check_value("servo_l", int'(servo_l), m_l);
        check_value("servo_r", int'(servo_r), m_r);
        check_value("state",   int'(state),   m_state);
        check_value("settled", int'(settled), m_settled);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < DIV; k++) begin
                run_cycles(1);
                if (m_ticked) break;
            end
        end
    endtask

    initial begin
        int v;
        model_reset();
        enable   = 1'b1;
        target_l = 8'd200;
        target_r = 8'd56;
        #1 rst = 1'b1;
        #1;
        check_value("reset_servo_l", int'(servo_l), 128);
        check_value("reset_servo_r", int'(servo_r), 128);
        check_value("reset_state",   int'(state),   0);
        check_value("reset_settled", int'(settled), 1);
        run_cycles(3);
        check_value("reset_hold_l", int'(servo_l), 128);

        // soft start
        @(negedge clk);
        rst = 1'b0;
        run_cycles(9);
        check_value("pre_first_tick_l", int'(servo_l), 128);
        run_cycles(1);
        check_value("first_tick_l", int'(servo_l), 132);
        check_value("first_tick_r", int'(servo_r), 124);
        check_value("ramp_settled", int'(settled), 0);
        run_cycles(169);
        check_value("tick17_l", int'(servo_l), 196);
        check_value("tick17_r", int'(servo_r), 60);
        run_cycles(1);
        check_value("tick18_l", int'(servo_l), 200);
        check_value("tick18_r", int'(servo_r), 56);
        run_cycles(1);
        check_value("hold_state",   int'(state),   2);
        check_value("hold_settled", int'(settled), 1);

        // exact landing
        target_l = 8'd202;
        run_ticks(1);
        check_value("land_l", int'(servo_l), 202);
        check_value("land_r", int'(servo_r), 56);
        run_cycles(1);
        check_value("land_state", int'(state), 2);
        target_l = 8'd200;
        run_ticks(1);
        run_cycles(1);
        check_value("back_l", int'(servo_l), 200);

        // brake, then reverse after 5 ticks
        enable = 1'b0;
        run_cycles(2);
        check_value("brake_state", int'(state), 3);
        run_ticks(5);
        check_value("brake5_l", int'(servo_l), 180);
        check_value("brake5_r", int'(servo_r), 76);
        enable = 1'b1;
        run_cycles(2);
        check_value("reverse_state", int'(state), 1);
        run_ticks(4);
        check_value("reverse4_l", int'(servo_l), 196);
        run_ticks(1);
        check_value("reverse5_l", int'(servo_l), 200);
        check_value("reverse5_r", int'(servo_r), 56);
        run_cycles(1);
        check_value("reverse_hold", int'(state), 2);

        // full brake to idle
        enable = 1'b0;
        run_ticks(17);
        check_value("brake17_l", int'(servo_l), 132);
        check_value("brake17_state", int'(state), 3);
        run_ticks(1);
        check_value("brake18_l", int'(servo_l), 128);
        check_value("brake18_r", int'(servo_r), 128);
        run_cycles(1);
        check_value("idle_state",   int'(state),   0);
        check_value("idle_settled", int'(settled), 1);

        // async reset mid-ramp
        enable = 1'b1;
        run_ticks(3);
        check_value("mid_ramp_l", int'(servo_l), 140);
        check_value("mid_ramp_r", int'(servo_r), 116);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_value("async_rst_l",     int'(servo_l), 128);
        check_value("async_rst_r",     int'(servo_r), 128);
        check_value("async_rst_state", int'(state),   0);
        check_value("async_rst_settled", int'(settled), 1);
        run_cycles(1);
        @(negedge clk);
        rst = 1'b0;
        run_cycles(9);
        check_value("restart_no_tick_l", int'(servo_l), 128);
        run_cycles(1);
        check_value("restart_tick_l", int'(servo_l), 132);
        check_value("restart_tick_r", int'(servo_r), 124);

        // randomized stimulus
        for (int it = 0; it < 250; it++) begin
            enable = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 2) == 0) begin
                v = m_l + int'($urandom_range(0, 8)) - 4;
                target_l = 8'((v < 0) ? 0 : ((v > 255) ? 255 : v));
                v = m_r + int'($urandom_range(0, 8)) - 4;
                target_r = 8'((v < 0) ? 0 : ((v > 255) ? 255 : v));
            end else begin
                target_l = 8'($urandom_range(0, 255));
                target_r = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 19) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                run_cycles(1);
                #2 rst = 1'b0;
            end
            run_cycles(int'($urandom_range(1, 300)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
